alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-requester arbiter and sequencer for the shared 32-bit RV32I ALU. It accepts operation requests from two clients (execute stage = requester 0, address/branch unit = requester 1) over valid/ready handshakes. It drives registered operands and control codes (ALUopr/SUBorSRA encoding) into the combinational ALU, captures the result and zero flag, and returns them on the granting requester's response channel. Exactly one operation is in flight at a time.

## Interface
- DATA_W, 32, operand/result width; must be 32 (ALU is fixed 32-bit)
- FIXED_PRIO, 0, 0 = round-robin between requesters; 1 = requester 0 always wins ties

- clk  in  1  single clock, rising edge
- reset  in  1  reset is synchronous and active-high
- reqN_valid  in  1  requester N (N=0,1) has an operation pending
- reqN_ready  out  1  arbiter accepts requester N this cycle
- reqN_data1, reqN_data2  in  DATA_W  operands
- reqN_opr  in  3  ALU operation code (ALU encoding: 000 add/sub, 001 sll, 010 slt, 011 sltu, 100 xor, 101 srl/sra, 110 or, 111 and)
- reqN_subsra  in  1  selects sub/sra for opr 000/101
- alu_data1, alu_data2  out  DATA_W  registered operands to ALU
- alu_opr  out  3  registered op code to ALU
- alu_subsra  out  1  registered SUBorSRA to ALU
- alu_out  in  DATA_W  ALU result (combinational from alu_* outputs)
- alu_z  in  1  ALU zero flag
- rspN_valid  out  1  result for requester N available
- rspN_ready  in  1  requester N consumes result
- rspN_result  out  DATA_W  captured result
- rspN_z  out  1  captured zero flag
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, EXEC, RESP. Reset → IDLE.
- IDLE: arbitration is combinational. reqN_ready=1 only for the granted requester, and only if its valid=1. At most one ready high. On the accept edge: latch data1/data2/opr/subsra into the alu_* registers, record owner=N, update last_grant=N, go to EXEC.
- Arbitration: a single valid wins. If both are valid: FIXED_PRIO=1 → requester 0; FIXED_PRIO=0 → the requester ≠ last_grant. last_grant resets to 1, so requester 0 wins the first tie.
- EXEC: alu_* stable for one full cycle. At the end of the cycle, capture alu_out→result_reg and alu_z→z_reg, then go to RESP.
- RESP: rsp[owner]_valid=1. The other rsp_valid is 0. rspN_result/rspN_z show result_reg/z_reg on both ports (qualified by valid). If rsp[owner]_ready=1, go to IDLE. Otherwise hold all values.
- reqN_ready=0 in EXEC and RESP regardless of valid. rspN_ready is ignored outside RESP and for the non-owner.
- Requesters must hold valid and operands stable until ready. The arbiter does not depend on this after the accept edge.
- alu_* registers hold their last values when idle (no toggling).
- No arithmetic here. Operands pass unmodified; opr/subsra pass bit-exact.

## Timing
- Reset values: all alu_* = 0, result_reg=0, z_reg=0, all rsp*_valid=0, all req*_ready=0 while reset high, busy=0, owner=0, last_grant=1.
- Accept at edge T (end of IDLE cycle) → EXEC during T+1 → rsp valid during T+2 (latency 2 cycles from accept).
- Minimum issue interval: 3 cycles (IDLE, EXEC, RESP with ready=1). Next accept possible at the end of the IDLE cycle following RESP.
- Response backpressure: RESP lasts until ready. Result, z, and owner are held bit-stable for every stall cycle.
- Reset asserted in any state: the transaction is dropped with no response, and next cycle is IDLE with reset values. A valid held across the reset deassert is accepted at the first IDLE cycle after reset.
- Request arriving during EXEC/RESP: waits. Arbitration uses only valids present in the IDLE cycle.
- Simultaneous rsp handshake and new request: the new request is accepted in the following IDLE cycle, not the same cycle.

## Test plan
- Single add: req0 opr=000 subsra=0 data 5,7 → req0_ready same cycle; rsp0_valid 2 cycles later with result 12, z=0; rsp1_valid stays 0.
- Sub to zero / SRA: req1 opr=000 subsra=1 data 0x10,0x10 → rsp1_result 0, z=1. Then opr=101 subsra=1 data 0x80000000,4 → 0xF8000000, z=0.
- Round-robin (FIXED_PRIO=0): both valid continuously with rsp_ready=1 → grants 0,1,0,1…, one accept every 3 cycles, never two readys high.
- Fixed priority (FIXED_PRIO=1): both valid for 12 cycles → four grants all to requester 0; requester 1 is granted only after req0_valid drops.
- Backpressure: rsp0_ready=0 for 4 cycles in RESP → rsp0_valid and result held 4 cycles, busy=1, req1_ready=0 despite req1_valid=1. Release → IDLE next cycle, then req1 accepted.
- Reset during EXEC: no rsp_valid ever for that op; all outputs at reset values the cycle after reset; a subsequent op completes normally.

Source files
------------

// File: rtl/alu_arbiter_if.sv
// Request, response and ALU-drive signals of the two-requester ALU arbiter.
// The slave modport is the arbiter's view; master is the requester/ALU side.
interface alu_arbiter_if #(
  parameter int DATA_W = 32
);
  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_data1;
  logic [DATA_W-1:0] req0_data2;
  logic [2:0]        req0_opr;
  logic              req0_subsra;

  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_data1;
  logic [DATA_W-1:0] req1_data2;
  logic [2:0]        req1_opr;
  logic              req1_subsra;

  logic [DATA_W-1:0] alu_data1;
  logic [DATA_W-1:0] alu_data2;
  logic [2:0]        alu_opr;
  logic              alu_subsra;
  logic [DATA_W-1:0] alu_out;
  logic              alu_z;

  logic              rsp0_valid;
  logic              rsp0_ready;
  logic [DATA_W-1:0] rsp0_result;
  logic              rsp0_z;

  logic              rsp1_valid;
  logic              rsp1_ready;
  logic [DATA_W-1:0] rsp1_result;
  logic              rsp1_z;

  logic              busy;

  modport slave (
    input  req0_valid, req0_data1, req0_data2, req0_opr, req0_subsra,
    input  req1_valid, req1_data1, req1_data2, req1_opr, req1_subsra,
    output req0_ready, req1_ready,
    output alu_data1, alu_data2, alu_opr, alu_subsra,
    input  alu_out, alu_z,
    output rsp0_valid, rsp0_result, rsp0_z,
    output rsp1_valid, rsp1_result, rsp1_z,
    input  rsp0_ready, rsp1_ready,
    output busy
  );

  modport master (
    output req0_valid, req0_data1, req0_data2, req0_opr, req0_subsra,
    output req1_valid, req1_data1, req1_data2, req1_opr, req1_subsra,
    input  req0_ready, req1_ready,
    input  alu_data1, alu_data2, alu_opr, alu_subsra,
    output alu_out, alu_z,
    input  rsp0_valid, rsp0_result, rsp0_z,
    input  rsp1_valid, rsp1_result, rsp1_z,
    output rsp0_ready, rsp1_ready,
    input  busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter/sequencer for the shared ALU; one op in flight, response 2 cycles after accept.
// Backpressure: RESP holds result/z/owner until the owner's rsp_ready; no request is accepted meanwhile.
module alu_arbiter #(
  parameter int DATA_W     = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic           clk,
  input  logic           reset,
  alu_arbiter_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_grant_q, last_grant_d;
  logic [DATA_W-1:0] data1_q, data1_d;
  logic [DATA_W-1:0] data2_q, data2_d;
  logic [2:0]        opr_q, opr_d;
  logic              subsra_q, subsra_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic              z_q, z_d;
  logic              grant0, grant1;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    data1_d      = data1_q;
    data2_d      = data2_q;
    opr_d        = opr_q;
    subsra_d     = subsra_q;
    result_d     = result_q;
    z_d          = z_q;
    grant0       = 1'b0;
    grant1       = 1'b0;

    // On a tie, round-robin favours whoever was not granted last.
    if (state_q == IDLE && !reset) begin
      if (bus.req0_valid && bus.req1_valid) begin
        if (FIXED_PRIO != 0 || last_grant_q) grant0 = 1'b1;
        else                                 grant1 = 1'b1;
      end else begin
        grant0 = bus.req0_valid;
        grant1 = bus.req1_valid;
      end
    end

    case (state_q)
      IDLE: begin
        if (grant0 || grant1) begin
          state_d      = EXEC;
          owner_d      = grant1;
          last_grant_d = grant1;
          data1_d      = grant1 ? bus.req1_data1  : bus.req0_data1;
          data2_d      = grant1 ? bus.req1_data2  : bus.req0_data2;
          opr_d        = grant1 ? bus.req1_opr    : bus.req0_opr;
          subsra_d     = grant1 ? bus.req1_subsra : bus.req0_subsra;
        end
      end
      EXEC: begin
        result_d = bus.alu_out;
        z_d      = bus.alu_z;
        state_d  = RESP;
      end
      RESP: begin
        if (owner_q ? bus.rsp1_ready : bus.rsp0_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      data1_q      <= '0;
      data2_q      <= '0;
      opr_q        <= '0;
      subsra_q     <= 1'b0;
      result_q     <= '0;
      z_q          <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      data1_q      <= data1_d;
      data2_q      <= data2_d;
      opr_q        <= opr_d;
      subsra_q     <= subsra_d;
      result_q     <= result_d;
      z_q          <= z_d;
    end
  end

  assign bus.req0_ready  = grant0;
  assign bus.req1_ready  = grant1;
  assign bus.alu_data1   = data1_q;
  assign bus.alu_data2   = data2_q;
  assign bus.alu_opr     = opr_q;
  assign bus.alu_subsra  = subsra_q;
  assign bus.rsp0_valid  = (state_q == RESP) && !owner_q;
  assign bus.rsp1_valid  = (state_q == RESP) &&  owner_q;
  assign bus.rsp0_result = result_q;
  assign bus.rsp1_result = result_q;
  assign bus.rsp0_z      = z_q;
  assign bus.rsp1_z      = z_q;
  assign bus.busy        = (state_q != IDLE);
endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: one round-robin and one fixed-priority instance share directed stimulus;
// a transaction-level model is compared every cycle and logged grants/responses are pinned to literals.
module tb_alu_arbiter;
  typedef struct packed {
    logic        vld;
    logic [31:0] d1;
    logic [31:0] d2;
    logic [2:0]  opr;
    logic        sub;
  } req_t;

  typedef struct packed {
    logic r0_rdy, r1_rdy, s0_vld, s1_vld;
    logic [31:0] s0_res, s1_res;
    logic s0_z, s1_z;
    logic [31:0] a1, a2;
    logic [2:0] opr;
    logic sub, busy;
  } obs_t;

  typedef struct packed {
    logic        owner;
    logic [31:0] res;
    logic        z;
  } rsp_t;

  typedef struct packed {
    logic        req;
    logic [31:0] d1, d2;
    logic [2:0]  opr;
    logic        sub;
    logic [31:0] res;
    logic        z;
  } single_t;

  logic       clk = 1'b0;
  logic       rst;
  req_t       rq0, rq1;
  logic [1:0] rsp_rdy;
  obs_t       obs [2];

  int   nvec = 0;
  int   nerr = 0;
  int   cyc  = 0;
  int   grant_log [2][$];
  rsp_t rsp_log   [2][$];
  int   stall_cnt [2];

  bit   m_busy [2];
  int   m_acc [2], m_owner [2], m_last [2];
  req_t m_op [2];
  logic [31:0] m_res [2];
  bit   m_z [2];

  single_t tbl [6] = '{
    '{1'b0, 32'd5,        32'd7,  3'b000, 1'b0, 32'd12,        1'b0},
    '{1'b1, 32'h10,       32'h10, 3'b000, 1'b1, 32'd0,         1'b1},
    '{1'b1, 32'h80000000, 32'd4,  3'b101, 1'b1, 32'hF8000000,  1'b0},
    '{1'b0, 32'hFFFFFFFF, 32'd1,  3'b010, 1'b0, 32'd1,         1'b0},
    '{1'b0, 32'h80000000, 32'd4,  3'b101, 1'b0, 32'h08000000,  1'b0},
    '{1'b1, 32'd1,        32'd31, 3'b001, 1'b0, 32'h80000000,  1'b0}
  };

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_fn(input logic [2:0] opr, input logic sub,
                                         input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    logic [31:0] r;
    sa = a;
    case (opr)
      3'b000: r = sub ? a - b : a + b;
      3'b001: r = a << b[4:0];
      3'b010: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'b011: r = (a < b) ? 32'd1 : 32'd0;
      3'b100: r = a ^ b;
      3'b101: begin
        if (sub) r = sa >>> b[4:0];
        else     r = a >> b[4:0];
      end
      3'b110: r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : u
    alu_arbiter_if #(.DATA_W(32)) bus ();
    assign bus.req0_valid  = rq0.vld;
    assign bus.req0_data1  = rq0.d1;
    assign bus.req0_data2  = rq0.d2;
    assign bus.req0_opr    = rq0.opr;
    assign bus.req0_subsra = rq0.sub;
    assign bus.req1_valid  = rq1.vld;
    assign bus.req1_data1  = rq1.d1;
    assign bus.req1_data2  = rq1.d2;
    assign bus.req1_opr    = rq1.opr;
    assign bus.req1_subsra = rq1.sub;
    assign bus.rsp0_ready  = rsp_rdy[0];
    assign bus.rsp1_ready  = rsp_rdy[1];
    assign bus.alu_out     = alu_fn(bus.alu_opr, bus.alu_subsra, bus.alu_data1, bus.alu_data2);
    assign bus.alu_z       = (bus.alu_out == 32'd0);

    alu_arbiter #(.DATA_W(32), .FIXED_PRIO(g)) dut (
      .clk   (clk),
      .reset (rst),
      .bus   (bus)
    );

    assign obs[g] = '{r0_rdy: bus.req0_ready, r1_rdy: bus.req1_ready,
                      s0_vld: bus.rsp0_valid, s1_vld: bus.rsp1_valid,
                      s0_res: bus.rsp0_result, s1_res: bus.rsp1_result,
                      s0_z: bus.rsp0_z, s1_z: bus.rsp1_z,
                      a1: bus.alu_data1, a2: bus.alu_data2,
                      opr: bus.alu_opr, sub: bus.alu_subsra, busy: bus.busy};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset(input int g);
    m_busy[g] = 1'b0; m_acc[g] = 0; m_owner[g] = 0; m_last[g] = 1;
    m_op[g] = '0; m_res[g] = '0; m_z[g] = 1'b0;
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        int w;
        bit resp;
        string tag;
        tag = $sformatf("i%0d c%0d", g, cyc);
        w = -1;
        if (rq0.vld && rq1.vld) w = (g == 1) ? 0 : 1 - m_last[g];
        else if (rq0.vld)       w = 0;
        else if (rq1.vld)       w = 1;
        resp = m_busy[g] && (cyc >= m_acc[g] + 2);

        check({tag, " req0_ready"}, obs[g].r0_rdy, !m_busy[g] && !rst && w == 0);
        check({tag, " req1_ready"}, obs[g].r1_rdy, !m_busy[g] && !rst && w == 1);
        check({tag, " rsp0_valid"}, obs[g].s0_vld, resp && m_owner[g] == 0);
        check({tag, " rsp1_valid"}, obs[g].s1_vld, resp && m_owner[g] == 1);
        check({tag, " busy"},       obs[g].busy,   m_busy[g]);
        check({tag, " alu_data1"},  obs[g].a1,     m_op[g].d1);
        check({tag, " alu_data2"},  obs[g].a2,     m_op[g].d2);
        check({tag, " alu_opr"},    obs[g].opr,    m_op[g].opr);
        check({tag, " alu_subsra"}, obs[g].sub,    m_op[g].sub);
        check({tag, " rsp0_result"}, obs[g].s0_res, m_res[g]);
        check({tag, " rsp1_result"}, obs[g].s1_res, m_res[g]);
        check({tag, " rsp0_z"},     obs[g].s0_z,   m_z[g]);
        check({tag, " rsp1_z"},     obs[g].s1_z,   m_z[g]);

        if (obs[g].r0_rdy && rq0.vld) grant_log[g].push_back(0);
        if (obs[g].r1_rdy && rq1.vld) grant_log[g].push_back(1);
        if (obs[g].s0_vld && rsp_rdy[0]) rsp_log[g].push_back(rsp_t'{1'b0, obs[g].s0_res, obs[g].s0_z});
        if (obs[g].s1_vld && rsp_rdy[1]) rsp_log[g].push_back(rsp_t'{1'b1, obs[g].s1_res, obs[g].s1_z});
        if (obs[g].s0_vld && !rsp_rdy[0]) stall_cnt[g]++;

        if (rst) begin
          model_reset(g);
        end else if (!m_busy[g] && w >= 0) begin
          m_busy[g] = 1'b1; m_acc[g] = cyc; m_owner[g] = w; m_last[g] = w;
          m_op[g] = (w == 1) ? rq1 : rq0;
        end else if (m_busy[g] && cyc == m_acc[g] + 1) begin
          m_res[g] = alu_fn(m_op[g].opr, m_op[g].sub, m_op[g].d1, m_op[g].d2);
          m_z[g]   = (m_res[g] == 32'd0);
        end else if (resp && rsp_rdy[m_owner[g]]) begin
          m_busy[g] = 1'b0;
        end
      end
      cyc++;
    end
  endtask

  initial begin
    int exp_rr [5] = '{0, 1, 0, 1, 1};
    int exp_fp [5] = '{0, 0, 0, 0, 1};
    rst = 1'b1; rq0 = '0; rq1 = '0; rsp_rdy = 2'b11;
    for (int g = 0; g < 2; g++) begin
      model_reset(g);
      stall_cnt[g] = 0;
    end
    repeat (2) @(posedge clk);
    fork
      monitor();
    join_none
    tick(1);
    rst = 1'b0;

    // Isolated operations, one per requester, spaced by the minimum issue interval.
    for (int i = 0; i < 6; i++) begin
      req_t r;
      r = '{1'b1, tbl[i].d1, tbl[i].d2, tbl[i].opr, tbl[i].sub};
      if (tbl[i].req) rq1 = r; else rq0 = r;
      tick(1);
      rq0.vld = 1'b0; rq1.vld = 1'b0;
      tick(2);
      for (int g = 0; g < 2; g++) begin
        check($sformatf("single%0d i%0d grant", i, g), grant_log[g][i], tbl[i].req);
        check($sformatf("single%0d i%0d owner", i, g), rsp_log[g][i].owner, tbl[i].req);
        check($sformatf("single%0d i%0d result", i, g), rsp_log[g][i].res, tbl[i].res);
        check($sformatf("single%0d i%0d z", i, g), rsp_log[g][i].z, tbl[i].z);
      end
    end

    // Both requesters valid for 12 cycles, then only requester 1 for one more.
    rq0 = '{1'b1, 32'd1, 32'd2, 3'b000, 1'b0};
    rq1 = '{1'b1, 32'hFF, 32'h0F, 3'b100, 1'b0};
    tick(12);
    rq0.vld = 1'b0;
    tick(1);
    rq1.vld = 1'b0;
    tick(6);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("tie i%0d grant count", g), grant_log[g].size(), 11);
      for (int k = 0; k < 5; k++) begin
        int e;
        e = (g == 1) ? exp_fp[k] : exp_rr[k];
        check($sformatf("tie i%0d grant%0d", g, k), grant_log[g][6+k], e);
        check($sformatf("tie i%0d result%0d", g, k), rsp_log[g][6+k].res, (e == 1) ? 32'hF0 : 32'd3);
      end
    end

    // Requester 0 response stalled 4 cycles while requester 1 waits.
    rsp_rdy[0] = 1'b0;
    rq0 = '{1'b1, 32'hF0, 32'h0F, 3'b110, 1'b0};
    tick(1);
    rq0.vld = 1'b0;
    rq1 = '{1'b1, 32'hF0, 32'h3C, 3'b111, 1'b0};
    tick(5);
    rsp_rdy[0] = 1'b1;
    tick(2);
    rq1.vld = 1'b0;
    tick(4);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("bp i%0d stall cycles", g), stall_cnt[g], 4);
      check($sformatf("bp i%0d result0", g), rsp_log[g][11].res, 32'hFF);
      check($sformatf("bp i%0d owner1", g), rsp_log[g][12].owner, 1'b1);
      check($sformatf("bp i%0d result1", g), rsp_log[g][12].res, 32'h30);
    end

    // Reset while an op is in EXEC; requester 1 holds valid across the reset.
    rq0 = '{1'b1, 32'd100, 32'd200, 3'b000, 1'b0};
    tick(1);
    rq0.vld = 1'b0;
    rst = 1'b1;
    rq1 = '{1'b1, 32'd1, 32'd2, 3'b011, 1'b0};
    tick(1);
    rst = 1'b0;
    tick(1);
    rq1.vld = 1'b0;
    tick(4);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("rst i%0d grant count", g), grant_log[g].size(), 15);
      check($sformatf("rst i%0d grant after reset", g), grant_log[g][14], 1);
      check($sformatf("rst i%0d response count", g), rsp_log[g].size(), 14);
      check($sformatf("rst i%0d owner", g), rsp_log[g][13].owner, 1'b1);
      check($sformatf("rst i%0d result", g), rsp_log[g][13].res, 32'd1);
      check($sformatf("rst i%0d z", g), rsp_log[g][13].z, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
